// File: rtl/ara_system_axi_arbiter.sv
// Two-master AXI4 arbiter: Ariane (0) and Ara (1) share one system port.
// AR/AW are round-robin, W follows AW grant order, R/B are routed by an extra ID MSB.
package ara_system_axi_arbiter_pkg;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned IdWidth   = 4;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic [3:0]           cache;
        logic [2:0]           prot;
    } slv_ax_t;

    typedef struct packed {
        logic [IdWidth:0]     id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic [3:0]           cache;
        logic [2:0]           prot;
    } mst_ax_t;

    typedef struct packed {
        logic [DataWidth-1:0]   data;
        logic [DataWidth/8-1:0] strb;
        logic                   last;
    } w_t;

    typedef struct packed { logic [IdWidth-1:0] id; logic [1:0] resp; } slv_b_t;
    typedef struct packed { logic [IdWidth:0]   id; logic [1:0] resp; } mst_b_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
    } slv_r_t;

    typedef struct packed {
        logic [IdWidth:0]     id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
    } mst_r_t;

    typedef struct packed {
        slv_ax_t aw; logic aw_valid; w_t w; logic w_valid; logic b_ready;
        slv_ax_t ar; logic ar_valid; logic r_ready;
    } slv_req_t;

    typedef struct packed {
        logic aw_ready; logic ar_ready; logic w_ready;
        logic b_valid; slv_b_t b; logic r_valid; slv_r_t r;
    } slv_resp_t;

    typedef struct packed {
        mst_ax_t aw; logic aw_valid; w_t w; logic w_valid; logic b_ready;
        mst_ax_t ar; logic ar_valid; logic r_ready;
    } mst_req_t;

    typedef struct packed {
        logic aw_ready; logic ar_ready; logic w_ready;
        logic b_valid; mst_b_t b; logic r_valid; mst_r_t r;
    } mst_resp_t;
endpackage

module ara_system_axi_arbiter #(
    parameter int unsigned AxiAddrWidth = ara_system_axi_arbiter_pkg::AddrWidth,
    parameter int unsigned AxiDataWidth = ara_system_axi_arbiter_pkg::DataWidth,
    parameter int unsigned AxiIdWidth   = ara_system_axi_arbiter_pkg::IdWidth,
    parameter int unsigned MaxWrTxns    = 4,
    parameter type slv_req_t  = ara_system_axi_arbiter_pkg::slv_req_t,
    parameter type slv_resp_t = ara_system_axi_arbiter_pkg::slv_resp_t,
    parameter type mst_req_t  = ara_system_axi_arbiter_pkg::mst_req_t,
    parameter type mst_resp_t = ara_system_axi_arbiter_pkg::mst_resp_t
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  slv_req_t  slv_req_i  [2],
    output slv_resp_t slv_resp_o [2],
    output mst_req_t  mst_req_o,
    input  mst_resp_t mst_resp_i
);
    localparam int unsigned PtrWidth = $clog2(MaxWrTxns);
    localparam int unsigned CntWidth = PtrWidth + 1;

    logic ar_lock_q, ar_idx_q, ar_last_q, ar_idx, ar_valid;
    logic aw_lock_q, aw_idx_q, aw_last_q, aw_idx, aw_valid, aw_hs;
    logic [MaxWrTxns-1:0] order_q;
    logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0]  cnt_q;
    logic fifo_full, fifo_empty, w_head, w_valid, w_pop;
    logic r_sel, b_sel;

    // Grant: a locked channel keeps its index, otherwise round-robin on ties.
    always_comb begin
        if (ar_lock_q)                                           ar_idx = ar_idx_q;
        else if (slv_req_i[0].ar_valid && slv_req_i[1].ar_valid) ar_idx = ~ar_last_q;
        else                                                     ar_idx = slv_req_i[1].ar_valid;
        if (aw_lock_q)                                           aw_idx = aw_idx_q;
        else if (slv_req_i[0].aw_valid && slv_req_i[1].aw_valid) aw_idx = ~aw_last_q;
        else                                                     aw_idx = slv_req_i[1].aw_valid;
    end

    assign fifo_full  = (cnt_q == CntWidth'(MaxWrTxns));
    assign fifo_empty = (cnt_q == '0);
    assign w_head     = order_q[rd_ptr_q];
    assign ar_valid   = rst_ni & slv_req_i[ar_idx].ar_valid;
    assign aw_valid   = rst_ni & ~fifo_full & slv_req_i[aw_idx].aw_valid;
    assign aw_hs      = aw_valid & mst_resp_i.aw_ready;
    assign w_valid    = rst_ni & ~fifo_empty & slv_req_i[w_head].w_valid;
    assign w_pop      = w_valid & mst_resp_i.w_ready & slv_req_i[w_head].w.last;
    assign r_sel      = mst_resp_i.r.id[AxiIdWidth];
    assign b_sel      = mst_resp_i.b.id[AxiIdWidth];

    always_comb begin
        mst_req_o          = '0;
        mst_req_o.ar.id    = {ar_idx, slv_req_i[ar_idx].ar.id};
        mst_req_o.ar.addr  = AxiAddrWidth'(slv_req_i[ar_idx].ar.addr);
        mst_req_o.ar.len   = slv_req_i[ar_idx].ar.len;
        mst_req_o.ar.size  = slv_req_i[ar_idx].ar.size;
        mst_req_o.ar.burst = slv_req_i[ar_idx].ar.burst;
        mst_req_o.ar.cache = slv_req_i[ar_idx].ar.cache;
        mst_req_o.ar.prot  = slv_req_i[ar_idx].ar.prot;
        mst_req_o.ar_valid = ar_valid;
        mst_req_o.aw.id    = {aw_idx, slv_req_i[aw_idx].aw.id};
        mst_req_o.aw.addr  = AxiAddrWidth'(slv_req_i[aw_idx].aw.addr);
        mst_req_o.aw.len   = slv_req_i[aw_idx].aw.len;
        mst_req_o.aw.size  = slv_req_i[aw_idx].aw.size;
        mst_req_o.aw.burst = slv_req_i[aw_idx].aw.burst;
        mst_req_o.aw.cache = slv_req_i[aw_idx].aw.cache;
        mst_req_o.aw.prot  = slv_req_i[aw_idx].aw.prot;
        mst_req_o.aw_valid = aw_valid;
        mst_req_o.w.data   = AxiDataWidth'(slv_req_i[w_head].w.data);
        mst_req_o.w.strb   = slv_req_i[w_head].w.strb;
        mst_req_o.w.last   = slv_req_i[w_head].w.last;
        mst_req_o.w_valid  = w_valid;
        mst_req_o.r_ready  = rst_ni & slv_req_i[r_sel].r_ready;
        mst_req_o.b_ready  = rst_ni & slv_req_i[b_sel].b_ready;
    end

    // Response payloads go to both masters; only the targeted one sees valid.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            slv_resp_o[i]        = '0;
            slv_resp_o[i].b.id   = mst_resp_i.b.id[AxiIdWidth-1:0];
            slv_resp_o[i].b.resp = mst_resp_i.b.resp;
            slv_resp_o[i].r.id   = mst_resp_i.r.id[AxiIdWidth-1:0];
            slv_resp_o[i].r.data = AxiDataWidth'(mst_resp_i.r.data);
            slv_resp_o[i].r.resp = mst_resp_i.r.resp;
            slv_resp_o[i].r.last = mst_resp_i.r.last;
        end
        if (rst_ni) begin
            slv_resp_o[ar_idx].ar_ready = mst_resp_i.ar_ready;
            slv_resp_o[aw_idx].aw_ready = ~fifo_full & mst_resp_i.aw_ready;
            if (!fifo_empty) slv_resp_o[w_head].w_ready = mst_resp_i.w_ready;
            slv_resp_o[r_sel].r_valid = mst_resp_i.r_valid;
            slv_resp_o[b_sel].b_valid = mst_resp_i.b_valid;
        end
    end

    // Full is taken from the registered count, so a pop never frees a slot in its own cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ar_lock_q <= 1'b0;
            ar_idx_q  <= 1'b0;
            ar_last_q <= 1'b1;
            aw_lock_q <= 1'b0;
            aw_idx_q  <= 1'b0;
            aw_last_q <= 1'b1;
            order_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            if (ar_valid && mst_resp_i.ar_ready) begin
                ar_lock_q <= 1'b0;
                ar_last_q <= ar_idx;
            end else if (ar_valid) begin
                ar_lock_q <= 1'b1;
                ar_idx_q  <= ar_idx;
            end
            if (aw_hs) begin
                aw_lock_q         <= 1'b0;
                aw_last_q         <= aw_idx;
                order_q[wr_ptr_q] <= aw_idx;
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end else if (aw_valid) begin
                aw_lock_q <= 1'b1;
                aw_idx_q  <= aw_idx;
            end
            if (w_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (aw_hs && !w_pop)      cnt_q <= cnt_q + 1'b1;
            else if (!aw_hs && w_pop) cnt_q <= cnt_q - 1'b1;
        end
    end
endmodule

// File: tb/tb_ara_system_axi_arbiter.sv
// Directed bench for ara_system_axi_arbiter: reset, ID tagging, round-robin,
// AW lock, W ordering, FIFO full and B routing, each with hand-computed values.
module tb_ara_system_axi_arbiter;
    import ara_system_axi_arbiter_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    slv_req_t  slv_req  [2];
    slv_resp_t slv_resp [2];
    mst_req_t  mst_req;
    mst_resp_t mst_resp;
    int        n_cmp = 0;
    int        n_err = 0;

    always #5 clk = ~clk;

    ara_system_axi_arbiter #(
        .AxiAddrWidth(32), .AxiDataWidth(32), .AxiIdWidth(4), .MaxWrTxns(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .slv_req_i(slv_req), .slv_resp_o(slv_resp),
        .mst_req_o(mst_req), .mst_resp_i(mst_resp)
    );

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clear_inputs();
        slv_req[0] = '0;
        slv_req[1] = '0;
        mst_resp   = '0;
    endtask

    // Leaves the bench at a negedge with reset released and all state cleared.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [255:0] rnd;
        logic [14:0]  got;
        @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < 8; k++) rnd[k*32 +: 32] = $urandom();
        slv_req[0] = rnd[$bits(slv_req_t)-1:0];
        for (int k = 0; k < 8; k++) rnd[k*32 +: 32] = $urandom();
        slv_req[1] = rnd[$bits(slv_req_t)-1:0];
        for (int k = 0; k < 8; k++) rnd[k*32 +: 32] = $urandom();
        mst_resp = rnd[$bits(mst_resp_t)-1:0];
        for (int i = 0; i < 2; i++) begin
            slv_req[i].ar_valid = 1'b1; slv_req[i].aw_valid = 1'b1; slv_req[i].w_valid = 1'b1;
            slv_req[i].r_ready  = 1'b1; slv_req[i].b_ready  = 1'b1;
        end
        mst_resp.ar_ready = 1'b1; mst_resp.aw_ready = 1'b1; mst_resp.w_ready = 1'b1;
        mst_resp.r_valid  = 1'b1; mst_resp.b_valid  = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            got = {mst_req.ar_valid, mst_req.aw_valid, mst_req.w_valid, mst_req.r_ready, mst_req.b_ready,
                   slv_resp[0].ar_ready, slv_resp[0].aw_ready, slv_resp[0].w_ready, slv_resp[0].r_valid,
                   slv_resp[0].b_valid, slv_resp[1].ar_ready, slv_resp[1].aw_ready, slv_resp[1].w_ready,
                   slv_resp[1].r_valid, slv_resp[1].b_valid};
            n_cmp++;
            if (got !== 15'd0) begin
                n_err++;
                $display("[TB] FAIL reset_outputs: got %b expected %b", got, 15'd0);
            end
            @(negedge clk);
        end
        do_reset();
    endtask

    task automatic test_id_tag();
        slv_req[1].ar_valid = 1'b1; slv_req[1].ar.id = 4'd3; slv_req[1].ar.addr = 32'h0000_1000;
        mst_resp.ar_ready = 1'b1;
        #1;
        n_cmp++;
        if ({mst_req.ar_valid, mst_req.ar.id} !== 6'b1_10011) begin
            n_err++;
            $display("[TB] FAIL tag_ar_id: got %b expected %b", {mst_req.ar_valid, mst_req.ar.id}, 6'b1_10011);
        end
        n_cmp++;
        if (mst_req.ar.addr !== 32'h0000_1000) begin
            n_err++;
            $display("[TB] FAIL tag_ar_addr: got %h expected %h", mst_req.ar.addr, 32'h0000_1000);
        end
        n_cmp++;
        if ({slv_resp[1].ar_ready, slv_resp[0].ar_ready} !== 2'b10) begin
            n_err++;
            $display("[TB] FAIL tag_ar_ready: got %b expected %b", {slv_resp[1].ar_ready, slv_resp[0].ar_ready}, 2'b10);
        end
        @(negedge clk);
        slv_req[1].ar_valid = 1'b0; mst_resp.ar_ready = 1'b0;
        mst_resp.r_valid = 1'b1; mst_resp.r.id = 5'b10011; mst_resp.r.data = 32'hCAFE_0001; mst_resp.r.last = 1'b1;
        slv_req[1].r_ready = 1'b1; slv_req[0].r_ready = 1'b0;
        #1;
        n_cmp++;
        if ({slv_resp[1].r_valid, slv_resp[1].r.id, slv_resp[1].r.data} !== {1'b1, 4'd3, 32'hCAFE_0001}) begin
            n_err++;
            $display("[TB] FAIL tag_r_route: got %h expected %h",
                     {slv_resp[1].r_valid, slv_resp[1].r.id, slv_resp[1].r.data}, {1'b1, 4'd3, 32'hCAFE_0001});
        end
        n_cmp++;
        if ({slv_resp[0].r_valid, mst_req.r_ready} !== 2'b01) begin
            n_err++;
            $display("[TB] FAIL tag_r_other: got %b expected %b", {slv_resp[0].r_valid, mst_req.r_ready}, 2'b01);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_id;
        logic [1:0] exp_rdy;
        do_reset();
        slv_req[0].ar_valid = 1'b1; slv_req[0].ar.id = 4'h5;
        slv_req[1].ar_valid = 1'b1; slv_req[1].ar.id = 4'hA;
        mst_resp.ar_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_id  = (k % 2 == 0) ? 5'b0_0101 : 5'b1_1010;
            exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
            n_cmp++;
            if (mst_req.ar.id !== exp_id) begin
                n_err++;
                $display("[TB] FAIL rr_grant_%0d: got %b expected %b", k, mst_req.ar.id, exp_id);
            end
            n_cmp++;
            if ({slv_resp[1].ar_ready, slv_resp[0].ar_ready} !== exp_rdy) begin
                n_err++;
                $display("[TB] FAIL rr_ready_%0d: got %b expected %b", k, {slv_resp[1].ar_ready, slv_resp[0].ar_ready}, exp_rdy);
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_aw_lock();
        do_reset();
        slv_req[1].aw_valid = 1'b1; slv_req[1].aw.id = 4'd2; slv_req[1].aw.addr = 32'h0000_2000;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) begin
                slv_req[0].aw_valid = 1'b1; slv_req[0].aw.id = 4'd7; slv_req[0].aw.addr = 32'h0000_3000;
            end
            #1;
            n_cmp++;
            if ({mst_req.aw_valid, mst_req.aw.id, mst_req.aw.addr} !== {1'b1, 5'b1_0010, 32'h0000_2000}) begin
                n_err++;
                $display("[TB] FAIL lock_hold_%0d: got %h expected %h", c,
                         {mst_req.aw_valid, mst_req.aw.id, mst_req.aw.addr}, {1'b1, 5'b1_0010, 32'h0000_2000});
            end
            n_cmp++;
            if ({slv_resp[1].aw_ready, slv_resp[0].aw_ready} !== 2'b00) begin
                n_err++;
                $display("[TB] FAIL lock_ready_%0d: got %b expected %b", c, {slv_resp[1].aw_ready, slv_resp[0].aw_ready}, 2'b00);
            end
            @(negedge clk);
        end
        mst_resp.aw_ready = 1'b1;
        #1;
        n_cmp++;
        if ({mst_req.aw.id, slv_resp[1].aw_ready, slv_resp[0].aw_ready} !== {5'b1_0010, 2'b10}) begin
            n_err++;
            $display("[TB] FAIL lock_handshake: got %b expected %b",
                     {mst_req.aw.id, slv_resp[1].aw_ready, slv_resp[0].aw_ready}, {5'b1_0010, 2'b10});
        end
        @(negedge clk);
        slv_req[1].aw_valid = 1'b0;
        #1;
        n_cmp++;
        if ({mst_req.aw.id, mst_req.aw.addr, slv_resp[0].aw_ready} !== {5'b0_0111, 32'h0000_3000, 1'b1}) begin
            n_err++;
            $display("[TB] FAIL lock_next_grant: got %h expected %h",
                     {mst_req.aw.id, mst_req.aw.addr, slv_resp[0].aw_ready}, {5'b0_0111, 32'h0000_3000, 1'b1});
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_w_order();
        logic [33:0] exp_w [5];
        logic [1:0]  exp_rdy [5];
        exp_w[0] = {1'b0, 32'h0, 1'b0};   exp_rdy[0] = 2'b00;
        exp_w[1] = {1'b1, 32'h11, 1'b0};  exp_rdy[1] = 2'b10;
        exp_w[2] = {1'b1, 32'h12, 1'b1};  exp_rdy[2] = 2'b10;
        exp_w[3] = {1'b1, 32'h21, 1'b0};  exp_rdy[3] = 2'b01;
        exp_w[4] = {1'b1, 32'h22, 1'b1};  exp_rdy[4] = 2'b01;
        do_reset();
        mst_resp.aw_ready = 1'b1; mst_resp.w_ready = 1'b1;
        slv_req[1].aw_valid = 1'b1; slv_req[1].aw.id = 4'd1;
        slv_req[1].w_valid = 1'b1; slv_req[1].w.data = 32'h11; slv_req[1].w.last = 1'b0;
        slv_req[0].w_valid = 1'b1; slv_req[0].w.data = 32'h21; slv_req[0].w.last = 1'b0;
        for (int c = 0; c < 6; c++) begin
            case (c)
                1: begin slv_req[1].aw_valid = 1'b0; slv_req[0].aw_valid = 1'b1; slv_req[0].aw.id = 4'd2; end
                2: begin slv_req[0].aw_valid = 1'b0; slv_req[1].w.data = 32'h12; slv_req[1].w.last = 1'b1; end
                3: slv_req[1].w_valid = 1'b0;
                4: begin slv_req[0].w.data = 32'h22; slv_req[0].w.last = 1'b1; end
                default: ;
            endcase
            #1;
            if (c == 0 || c == 5) begin
                n_cmp++;
                if ({mst_req.w_valid, slv_resp[1].w_ready, slv_resp[0].w_ready} !== 3'b000) begin
                    n_err++;
                    $display("[TB] FAIL w_idle_%0d: got %b expected %b", c,
                             {mst_req.w_valid, slv_resp[1].w_ready, slv_resp[0].w_ready}, 3'b000);
                end
            end else begin
                n_cmp++;
                if ({mst_req.w_valid, mst_req.w.data, mst_req.w.last} !== exp_w[c]) begin
                    n_err++;
                    $display("[TB] FAIL w_beat_%0d: got %h expected %h", c,
                             {mst_req.w_valid, mst_req.w.data, mst_req.w.last}, exp_w[c]);
                end
                n_cmp++;
                if ({slv_resp[1].w_ready, slv_resp[0].w_ready} !== exp_rdy[c]) begin
                    n_err++;
                    $display("[TB] FAIL w_ready_%0d: got %b expected %b", c,
                             {slv_resp[1].w_ready, slv_resp[0].w_ready}, exp_rdy[c]);
                end
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_fifo_full();
        do_reset();
        mst_resp.aw_ready = 1'b1;
        slv_req[0].aw_valid = 1'b1; slv_req[0].aw.id = 4'd3;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++;
            if ({mst_req.aw_valid, slv_resp[0].aw_ready} !== 2'b11) begin
                n_err++;
                $display("[TB] FAIL full_accept_%0d: got %b expected %b", k, {mst_req.aw_valid, slv_resp[0].aw_ready}, 2'b11);
            end
            @(negedge clk);
        end
        mst_resp.w_ready = 1'b1;
        slv_req[0].w_valid = 1'b1; slv_req[0].w.data = 32'h5A; slv_req[0].w.last = 1'b1;
        #1;
        n_cmp++;
        if ({mst_req.aw_valid, slv_resp[0].aw_ready, slv_resp[0].w_ready} !== 3'b001) begin
            n_err++;
            $display("[TB] FAIL full_block: got %b expected %b",
                     {mst_req.aw_valid, slv_resp[0].aw_ready, slv_resp[0].w_ready}, 3'b001);
        end
        @(negedge clk);
        slv_req[0].w_valid = 1'b0;
        #1;
        n_cmp++;
        if ({mst_req.aw_valid, slv_resp[0].aw_ready} !== 2'b11) begin
            n_err++;
            $display("[TB] FAIL full_after_pop: got %b expected %b", {mst_req.aw_valid, slv_resp[0].aw_ready}, 2'b11);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({mst_req.aw_valid, slv_resp[0].aw_ready} !== 2'b00) begin
            n_err++;
            $display("[TB] FAIL full_again: got %b expected %b", {mst_req.aw_valid, slv_resp[0].aw_ready}, 2'b00);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_b_interleave();
        logic [4:0] ids   [3];
        logic [1:0] rsps  [3];
        logic [1:0] rdy1  [3];
        logic [8:0] exp_b [3];
        ids[0] = 5'b0_0001; rsps[0] = 2'd0; rdy1[0] = 2'b01;
        ids[1] = 5'b1_0010; rsps[1] = 2'd2; rdy1[1] = 2'b01;
        ids[2] = 5'b1_0010; rsps[2] = 2'd2; rdy1[2] = 2'b10;
        exp_b[0] = {2'b01, 4'd1, 2'd0, 1'b1};
        exp_b[1] = {2'b10, 4'd2, 2'd2, 1'b0};
        exp_b[2] = {2'b10, 4'd2, 2'd2, 1'b1};
        do_reset();
        mst_resp.b_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            mst_resp.b.id = ids[c]; mst_resp.b.resp = rsps[c];
            slv_req[1].b_ready = rdy1[c][1]; slv_req[0].b_ready = rdy1[c][0];
            #1;
            n_cmp++;
            if ({slv_resp[1].b_valid, slv_resp[0].b_valid, slv_resp[ids[c][4]].b.id,
                 slv_resp[ids[c][4]].b.resp, mst_req.b_ready} !== exp_b[c]) begin
                n_err++;
                $display("[TB] FAIL b_route_%0d: got %b expected %b", c,
                         {slv_resp[1].b_valid, slv_resp[0].b_valid, slv_resp[ids[c][4]].b.id,
                          slv_resp[ids[c][4]].b.resp, mst_req.b_ready}, exp_b[c]);
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_id_tag();
        test_round_robin();
        test_aw_lock();
        test_w_order();
        test_fifo_full();
        test_b_interleave();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
